spine_output_arbiter: RTL and testbench

//  Packet-level round-robin arbiter for one spine-router output port. Up to NUM_REQ

---
 rtl/spine_output_arbiter.sv | 155 +++++++++++++++
 tb/tb_spine_output_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spine_output_arbiter.sv
// Packet-level round-robin arbiter for one spine-router output port.
// Locks a grant from the first flit of a packet through its last flit, steers the
// owner's flits into the output FIFO under its full flag, and force-releases an
// owner that stays empty too long.
module spine_output_arbiter #(
    parameter int unsigned NUM_REQ      = 11,
    parameter int unsigned DWIDTH       = 16,
    parameter int unsigned HOLD_TIMEOUT = 16,
    parameter int unsigned IDW          = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DWIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_pop,
    input  logic                      out_full,
    output logic [DWIDTH-1:0]         out_data,
    output logic                      out_valid,
    output logic [NUM_REQ-1:0]        grant,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned CntW = $clog2(HOLD_TIMEOUT);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StXfer = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [DWIDTH-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CntW-1:0]    idle_cnt_q, idle_cnt_d;

    logic               owner_valid;
    logic               owner_last;
    logic [DWIDTH-1:0]  owner_data;
    logic               pop;
    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic [IDW-1:0]     rr_next;

    // Select the current owner's flit, valid and last flags (grant_q is one-hot or zero).
    always_comb begin
        owner_valid = |(req_valid & grant_q);
        owner_last  = |(req_last & grant_q);
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_data = req_data[i*DWIDTH +: DWIDTH];
            end
        end
        pop     = (state_q == StXfer) && owner_valid && !out_full;
        req_pop = pop ? grant_q : '0;
    end

    // Round-robin scan starting at rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + 32'(k);
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
        rr_next = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
    end

    // Next-state logic: grant in IDLE, transfer / release / watchdog in XFER.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        out_data_d    = out_data_q;
        out_valid_d   = 1'b0;
        timeout_err_d = 1'b0;
        idle_cnt_d    = idle_cnt_q;

        if (state_q == StIdle) begin
            if (win_found) begin
                grant_d          = '0;
                grant_d[win_idx] = 1'b1;
                grant_id_d       = win_idx;
                idle_cnt_d       = '0;
                state_d          = StXfer;
            end
        end else begin
            if (pop) begin
                out_valid_d = 1'b1;
                out_data_d  = owner_data;
                idle_cnt_d  = '0;
                if (owner_last) begin
                    grant_d  = '0;
                    rr_ptr_d = rr_next;
                    state_d  = StIdle;
                end
            end else if (!owner_valid) begin
                // Owner FIFO empty: count toward forced release. Stalls on out_full hold.
                if (idle_cnt_q == CntW'(HOLD_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    grant_d       = '0;
                    rr_ptr_d      = rr_next;
                    idle_cnt_d    = '0;
                    state_d       = StIdle;
                end else begin
                    idle_cnt_d = idle_cnt_q + CntW'(1);
                end
            end
        end
    end

    // State registers; asynchronous reset drops any packet in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            grant_id_q    <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            idle_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            timeout_err_q <= timeout_err_d;
            idle_cnt_q    <= idle_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q == StXfer);

endmodule

// File: tb/tb_spine_output_arbiter.sv
// Self-checking bench for spine_output_arbiter: directed scenarios plus a randomized
// run compared against a behavioural packet-arbitration model.
module tb_spine_output_arbiter;

    localparam int N   = 11;
    localparam int DW  = 16;
    localparam int HT  = 16;
    localparam int IDW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic            out_full = 1'b0;
    logic [N-1:0]    req_pop;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic [N-1:0]    grant;
    logic [IDW-1:0]  grant_id;
    logic            busy;
    logic            timeout_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner index (-1 when idle), search start, empty-cycle count.
    int            m_owner;
    int            m_ptr;
    int            m_empty;
    int            m_gid;
    logic          m_ov;
    logic          m_to;
    logic [DW-1:0] m_od;

    always #5 clk = ~clk;

    spine_output_arbiter #(
        .NUM_REQ(N), .DWIDTH(DW), .HOLD_TIMEOUT(HT), .IDW(IDW)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_pop(req_pop), .out_full(out_full), .out_data(out_data),
        .out_valid(out_valid), .grant(grant), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err)
    );

    function automatic logic [N-1:0] onehot(int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] exp_pop();
        if (m_owner >= 0 && req_valid[m_owner] && !out_full) return onehot(m_owner);
        return '0;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_empty = 0; m_gid = 0;
        m_ov = 1'b0; m_to = 1'b0; m_od = '0;
    endtask

    // One clock of packet arbitration, evaluated on the inputs present before the edge.
    task automatic model_step();
        int g;
        m_ov = 1'b0;
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                g = (m_ptr + k) % N;
                if (m_owner < 0 && req_valid[g]) begin
                    m_owner = g; m_gid = g; m_empty = 0;
                end
            end
        end else begin
            g = m_owner;
            if (req_valid[g] && !out_full) begin
                m_ov = 1'b1; m_od = req_data[g*DW +: DW]; m_empty = 0;
                if (req_last[g]) begin
                    m_owner = -1; m_ptr = (g + 1) % N;
                end
            end else if (!req_valid[g]) begin
                m_empty++;
                if (m_empty == HT) begin
                    m_to = 1'b1; m_owner = -1; m_ptr = (g + 1) % N; m_empty = 0;
                end
            end
        end
    endtask

    task automatic tick();
        if (reset) model_step();
        else model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(int i, logic [DW-1:0] d, logic last);
        req_data[i*DW +: DW] = d;
        req_last[i] = last;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_last = '0; req_data = '0; out_full = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            req_valid = N'($urandom);
            req_last  = N'($urandom);
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
            out_full  = 1'($urandom);
            #1;
            checks++;
            if ({req_pop, grant, grant_id, out_valid, out_data, busy, timeout_err} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got pop=%h grant=%h id=%0d ov=%b od=%h busy=%b to=%b want all 0",
                         req_pop, grant, grant_id, out_valid, out_data, busy, timeout_err);
            end
            tick();
        end
        clear_inputs();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || grant !== '0) begin
                errors++;
                $display("FAIL reset_idle: got busy=%b grant=%h want busy=0 grant=0", busy, grant);
            end
        end
    endtask

    task automatic test_lone_requester();
        logic [DW-1:0] flits [3];
        flits[0] = 16'hA001; flits[1] = 16'hA002; flits[2] = 16'hA003;
        do_reset();
        req_valid = onehot(3);
        set_flit(3, flits[0], 1'b0);
        #1;
        checks++;
        if (grant !== '0) begin
            errors++; $display("FAIL lone_pre_grant: got %h want 0", grant);
        end
        tick();
        checks++;
        if (grant_id !== 4'd3 || grant !== onehot(3)) begin
            errors++; $display("FAIL lone_grant: got id=%0d grant=%h want id=3", grant_id, grant);
        end
        for (int k = 0; k < 3; k++) begin
            set_flit(3, flits[k], k == 2);
            #1;
            checks++;
            if (req_pop !== onehot(3)) begin
                errors++; $display("FAIL lone_pop: got %h want %h", req_pop, onehot(3));
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== flits[k]) begin
                errors++;
                $display("FAIL lone_flit: got v=%b d=%h want v=1 d=%h", out_valid, out_data, flits[k]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL lone_done_busy: got %b want 0", busy);
        end
        req_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL lone_no_extra: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req_valid = '1;
        for (int i = 0; i < N; i++) set_flit(i, 16'hC000 + 16'(i), 1'b1);
        #1;
        checks++;
        if (grant !== '0) begin
            errors++; $display("FAIL fair_pre_grant: got %h want 0", grant);
        end
        for (int k = 0; k <= N; k++) begin
            tick();
            checks++;
            if (grant !== onehot(k % N) || grant_id !== IDW'(k % N) || busy !== 1'b1) begin
                errors++;
                $display("FAIL fair_order: got id=%0d grant=%h busy=%b want id=%0d", grant_id,
                         grant, busy, k % N);
            end
            tick();
            checks++;
            if (grant !== '0 || busy !== 1'b0 || out_valid !== 1'b1 ||
                out_data !== 16'hC000 + 16'(k % N)) begin
                errors++;
                $display("FAIL fair_bubble: got grant=%h busy=%b v=%b d=%h want 0,0,1,%h", grant,
                         busy, out_valid, out_data, 16'hC000 + 16'(k % N));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] flits [4];
        logic [DW-1:0] got [$];
        logic          full;
        logic          prev_full;
        int            idx;
        flits[0] = 16'hB001; flits[1] = 16'hB002; flits[2] = 16'hB003; flits[3] = 16'hB004;
        do_reset();
        req_valid = onehot(5);
        set_flit(5, flits[0], 1'b0);
        tick();
        idx = 0;
        prev_full = 1'b0;
        for (int c = 0; c < 20; c++) begin
            full = (c >= 2 && c <= 6) || c == 8;
            if (idx < 4) set_flit(5, flits[idx], idx == 3);
            else req_valid = '0;
            out_full = full;
            #1;
            if (full) begin
                checks++;
                if (req_pop !== '0) begin
                    errors++; $display("FAIL bp_pop_while_full: got %h want 0 (c=%0d)", req_pop, c);
                end
            end
            if (prev_full) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++; $display("FAIL bp_valid_after_full: got %b want 0 (c=%0d)", out_valid, c);
                end
            end
            checks++;
            if (timeout_err !== 1'b0) begin
                errors++; $display("FAIL bp_timeout: got %b want 0 (c=%0d)", timeout_err, c);
            end
            if (c == 9) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL bp_last_held: got busy=%b want 1", busy);
                end
            end
            if (req_pop[5]) idx++;
            prev_full = full;
            tick();
            if (out_valid) got.push_back(out_data);
        end
        out_full = 1'b0;
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL bp_flit_count: got %0d want 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got[k] !== flits[k]) begin
                    errors++; $display("FAIL bp_flit_value: got %h want %h", got[k], flits[k]);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        int seen;
        do_reset();
        req_valid = onehot(7);
        set_flit(7, 16'hD001, 1'b0);
        tick();
        checks++;
        if (grant_id !== 4'd7) begin
            errors++; $display("FAIL wd_grant: got %0d want 7", grant_id);
        end
        tick();
        req_valid = onehot(6) | onehot(9);
        seen = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (timeout_err === 1'b1) begin
                seen = t;
                break;
            end
            checks++;
            if (grant !== onehot(7) || req_pop !== '0) begin
                errors++; $display("FAIL wd_locked: got grant=%h pop=%h want grant=%h pop=0",
                                   grant, req_pop, onehot(7));
            end
        end
        checks++;
        if (seen != HT) begin
            errors++; $display("FAIL wd_latency: got %0d want %0d cycles", seen, HT);
        end
        checks++;
        if (grant !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL wd_release: got grant=%h busy=%b want 0,0", grant, busy);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0 || grant_id !== 4'd9 || grant !== onehot(9)) begin
            errors++; $display("FAIL wd_next: got to=%b id=%0d want to=0 id=9", timeout_err, grant_id);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req_valid = onehot(9);
        set_flit(9, 16'hE009, 1'b1);
        tick();
        tick();
        req_valid = onehot(2);
        set_flit(2, 16'hE001, 1'b0);
        tick();
        checks++;
        if (grant_id !== 4'd2) begin
            errors++; $display("FAIL rm_grant: got %0d want 2", grant_id);
        end
        tick();
        set_flit(2, 16'hE002, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({req_pop, grant, grant_id, out_valid, out_data, busy, timeout_err} !== '0) begin
            errors++;
            $display("FAIL rm_async: got pop=%h grant=%h id=%0d ov=%b od=%h busy=%b want all 0",
                     req_pop, grant, grant_id, out_valid, out_data, busy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || grant !== '0) begin
            errors++; $display("FAIL rm_no_flit: got ov=%b grant=%h want 0", out_valid, grant);
        end
        reset = 1'b1;
        req_valid = onehot(0) | onehot(10);
        set_flit(0, 16'hE100, 1'b1);
        set_flit(10, 16'hE10A, 1'b1);
        tick();
        checks++;
        if (grant_id !== 4'd0 || grant !== onehot(0)) begin
            errors++; $display("FAIL rm_regrant: got id=%0d want 0", grant_id);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) req_valid[i] = ~req_valid[i];
                req_last[i] = ($urandom_range(3) == 0);
                req_data[i*DW +: DW] = DW'($urandom);
            end
            out_full = ($urandom_range(4) == 0);
            #1;
            checks++;
            if (req_pop !== exp_pop()) begin
                errors++; $display("FAIL rnd_pop: got %h want %h (c=%0d)", req_pop, exp_pop(), c);
            end
            checks++;
            if (grant !== onehot(m_owner) || busy !== (m_owner >= 0)) begin
                errors++; $display("FAIL rnd_grant: got %h busy=%b want %h (c=%0d)", grant, busy,
                                   onehot(m_owner), c);
            end
            checks++;
            if (grant_id !== IDW'(m_gid)) begin
                errors++; $display("FAIL rnd_grant_id: got %0d want %0d (c=%0d)", grant_id, m_gid, c);
            end
            checks++;
            if (out_valid !== m_ov || (m_ov && out_data !== m_od)) begin
                errors++; $display("FAIL rnd_out: got v=%b d=%h want v=%b d=%h (c=%0d)", out_valid,
                                   out_data, m_ov, m_od, c);
            end
            checks++;
            if (timeout_err !== m_to) begin
                errors++; $display("FAIL rnd_timeout: got %b want %b (c=%0d)", timeout_err, m_to, c);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lone_requester();
        test_fairness();
        test_backpressure();
        test_watchdog();
        test_reset_mid_packet();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
